// File: rtl/rr_grant_controller_if.sv
// Requester/consumer bundle for rr_grant_controller.
// The arbiter takes the slave side; the requester/consumer takes the master side.
interface rr_grant_controller_if #(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2
);
  logic [N_REQ-1:0] req;
  logic             arb_ack;
  logic             grant_valid;
  logic [IDX_W-1:0] grant_idx;
  logic [N_REQ-1:0] grant_onehot;
  logic             arb_timeout;

  modport master (
    output req, arb_ack,
    input  grant_valid, grant_idx,
    input  grant_onehot, arb_timeout
  );

  modport slave (
    input  req, arb_ack,
    output grant_valid, grant_idx,
    output grant_onehot, arb_timeout
  );
endinterface

// File: rtl/rr_grant_controller.sv
// Registered round-robin arbiter with grant/ack handshake.
// Optional grant revoke after TIMEOUT cycles: define ARB_TIMEOUT_EN.
module rr_grant_controller #(
  parameter int N_REQ   = 4,
  parameter int IDX_W   = 2,
  parameter int TIMEOUT = 16
) (
  input logic                  clk,
  input logic                  rst,
  rr_grant_controller_if.slave bus
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  if (IDX_W != $clog2(N_REQ) || (1 << IDX_W) != N_REQ ||
      TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_cfg
    $error("rr_grant_controller: bad parameters");
  end

  logic [0:0]       state;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] idx_q;
  logic [N_REQ-1:0] oh_q;
  logic             valid_q;
  logic [IDX_W-1:0] base;
  logic [IDX_W-1:0] cand;
  logic [IDX_W-1:0] win_idx;
  logic [N_REQ-1:0] win_oh;
  logic             win_found;
  logic             adv;

`ifdef ARB_TIMEOUT_EN
  logic [7:0] cnt;
  logic       to_q;
  logic       expire;

  assign expire = (state == GRANT) && !bus.arb_ack &&
                  (cnt == 8'(TIMEOUT - 1));
  assign adv    = bus.arb_ack | expire;
`else
  assign adv = bus.arb_ack;
`endif

  // Once granted, the search restarts after the current winner.
  assign base = (state == GRANT) ? idx_q : ptr;

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = base + IDX_W'(k);
      if (!win_found && bus.req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign win_oh = {{(N_REQ-1){1'b0}}, 1'b1} << win_idx;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      ptr     <= IDX_W'(N_REQ - 1);
      idx_q   <= '0;
      oh_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (win_found) begin
            idx_q   <= win_idx;
            oh_q    <= win_oh;
            valid_q <= 1'b1;
            state   <= GRANT;
          end
        end
        GRANT: begin
          if (adv) begin
            ptr <= idx_q;
            if (win_found) begin
              idx_q <= win_idx;
              oh_q  <= win_oh;
            end else begin
              valid_q <= 1'b0;
              oh_q    <= '0;
              state   <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt  <= '0;
      to_q <= 1'b0;
    end else begin
      to_q <= expire;
      if (state == IDLE || adv) cnt <= '0;
      else                      cnt <= cnt + 8'd1;
    end
  end

  assign bus.arb_timeout = to_q;
`else
  assign bus.arb_timeout = 1'b0;
`endif

  assign bus.grant_valid  = valid_q;
  assign bus.grant_idx    = idx_q;
  assign bus.grant_onehot = oh_q;

endmodule

// File: tb/tb_rr_grant_controller.sv
// Directed bench for rr_grant_controller.
// Expected values are hand-computed round-robin outcomes.
module tb_rr_grant_controller;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;

  rr_grant_controller_if #(.N_REQ(4), .IDX_W(2)) bus ();

  rr_grant_controller #(
    .N_REQ(4), .IDX_W(2), .TIMEOUT(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ack_step();
    bus.arb_ack = 1'b1;
    step();
    bus.arb_ack = 1'b0;
  endtask

  int seq[4] = '{1, 2, 3, 0};
  int prev;

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst         = 1'b0;
    bus.req     = 4'b0000;
    bus.arb_ack = 1'b0;
    repeat (3) step();
    check("rst_valid", 32'(bus.grant_valid), 32'd0);
    check("rst_idx", 32'(bus.grant_idx), 32'd0);
    check("rst_oh", 32'(bus.grant_onehot), 32'd0);
    check("rst_to", 32'(bus.arb_timeout), 32'd0);
    rst = 1'b1;

    for (int i = 0; i < 5; i++) begin
      step();
      check("idle_valid", 32'(bus.grant_valid), 32'd0);
      check("idle_oh", 32'(bus.grant_onehot), 32'd0);
    end

    bus.req = 4'b1010;
    step();
    check("first_valid", 32'(bus.grant_valid), 32'd1);
    check("first_idx", 32'(bus.grant_idx), 32'd1);
    check("first_oh", 32'(bus.grant_onehot), 32'h2);

    for (int i = 0; i < 10; i++) begin
      if (i == 3) bus.req = 4'b1000;
      step();
      check("hold_valid", 32'(bus.grant_valid), 32'd1);
      check("hold_idx", 32'(bus.grant_idx), 32'd1);
      check("hold_oh", 32'(bus.grant_onehot), 32'h2);
    end

    #2 rst = 1'b0;
    #1;
    check("arst_valid", 32'(bus.grant_valid), 32'd0);
    check("arst_oh", 32'(bus.grant_onehot), 32'd0);
    check("arst_idx", 32'(bus.grant_idx), 32'd0);
    rst = 1'b1;

    bus.req = 4'b1111;
    step();
    check("rr0_valid", 32'(bus.grant_valid), 32'd1);
    check("rr0_idx", 32'(bus.grant_idx), 32'd0);
    prev = 0;
    foreach (seq[j]) begin
      repeat (2) begin
        step();
        check("rr_hold", 32'(bus.grant_idx), 32'(prev));
        check("rr_valid", 32'(bus.grant_valid), 32'd1);
      end
      ack_step();
      check("rr_valid", 32'(bus.grant_valid), 32'd1);
      check("rr_idx", 32'(bus.grant_idx), 32'(seq[j]));
      check("rr_oh", 32'(bus.grant_onehot), 32'd1 << seq[j]);
      prev = seq[j];
    end

    bus.req = 4'b1000;
    ack_step();
    check("to3_idx", 32'(bus.grant_idx), 32'd3);
    bus.req = 4'b1001;
    ack_step();
    check("wrap_idx", 32'(bus.grant_idx), 32'd0);
    check("wrap_valid", 32'(bus.grant_valid), 32'd1);
    ack_step();
    check("wrap2_idx", 32'(bus.grant_idx), 32'd3);

    bus.req = 4'b0000;
    ack_step();
    check("drop_valid", 32'(bus.grant_valid), 32'd0);
    check("drop_oh", 32'(bus.grant_onehot), 32'd0);
    check("drop_idx", 32'(bus.grant_idx), 32'd3);
    ack_step();
    check("idle_ack", 32'(bus.grant_valid), 32'd0);

    bus.req = 4'b0100;
    step();
    check("g2_valid", 32'(bus.grant_valid), 32'd1);
    check("g2_idx", 32'(bus.grant_idx), 32'd2);
    check("g2_oh", 32'(bus.grant_onehot), 32'h4);

`ifndef ARB_TIMEOUT_EN
    for (int i = 0; i < 20; i++) begin
      step();
      check("noto_pulse", 32'(bus.arb_timeout), 32'd0);
      check("noto_idx", 32'(bus.grant_idx), 32'd2);
    end
`endif

    ack_step();
    check("single_valid", 32'(bus.grant_valid), 32'd1);
    check("single_idx", 32'(bus.grant_idx), 32'd2);

    #2 rst = 1'b0;
    #1;
    check("mid_rst_valid", 32'(bus.grant_valid), 32'd0);
    check("mid_rst_oh", 32'(bus.grant_onehot), 32'd0);
    #1 rst = 1'b1;
    step();
    check("post_rst_valid", 32'(bus.grant_valid), 32'd1);
    check("post_rst_idx", 32'(bus.grant_idx), 32'd2);

`ifdef ARB_TIMEOUT_EN
    #2 rst = 1'b0;
    #1 rst = 1'b1;
    bus.req = 4'b0011;
    step();
    check("to_start", 32'(bus.grant_idx), 32'd0);
    for (int k = 1; k <= 15; k++) begin
      step();
      check("to_wait", 32'(bus.arb_timeout), 32'd0);
      check("to_wait_idx", 32'(bus.grant_idx), 32'd0);
    end
    step();
    check("to_pulse", 32'(bus.arb_timeout), 32'd1);
    check("to_next", 32'(bus.grant_idx), 32'd1);
    check("to_valid", 32'(bus.grant_valid), 32'd1);
    for (int k = 1; k <= 15; k++) begin
      step();
      check("to2_wait", 32'(bus.arb_timeout), 32'd0);
      check("to2_idx", 32'(bus.grant_idx), 32'd1);
    end
    ack_step();
    check("to_ack_pulse", 32'(bus.arb_timeout), 32'd0);
    check("to_ack_idx", 32'(bus.grant_idx), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/rr_grant_controller.md
Name: rr_grant_controller

Overview:
- Registered round-robin arbiter that shares one resource among N requesters using a grant/acknowledge handshake.
- A winner is presented on grant_idx/grant_onehot and held stable until the consumer pulses arb_ack; only then does the next winner appear.
- Fairness: the search restarts one position after the last acknowledged winner.
- Sits between the requester bus and the shared resource; supplies the winner index that the downstream datapath consumes.

Parameters:
- N_REQ, 4, number of requesters (power of two, 2..16).
- IDX_W, 2, width of grant index; must equal log2(N_REQ).
- TIMEOUT, 16, cycles to wait for arb_ack before revoking (used only with ARB_TIMEOUT_EN); range 2..255.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- req  input  N_REQ  request vector; bit i high = requester i wants the resource.
- arb_ack  input  1  single-cycle pulse from consumer: current grant consumed.
- grant_valid  output  1  grant outputs are valid and stable.
- grant_idx  output  IDX_W  index of the granted requester.
- grant_onehot  output  N_REQ  one-hot form of grant_idx; all-zero when grant_valid=0.
- arb_timeout  output  1  one-cycle pulse on grant revoke; tied 0 without ARB_TIMEOUT_EN.

Behaviour:
- Reset (rst=0, asynchronous, immediate):
  - grant_valid=0, grant_idx=0, grant_onehot=0, arb_timeout=0.
  - Internal last-winner pointer ptr=N_REQ-1, so the first search starts at requester 0.
  - state=IDLE; timeout counter=0.
- All outputs are registered. There is no combinational path from req or arb_ack to any output.
- Winner function: first set bit of req in circular order ptr+1, ptr+2, ..., ptr (mod N_REQ). ptr itself has the lowest priority.
- State IDLE:
  - Sample req each cycle.
  - If req!=0: on the next edge load the winner, set grant_valid=1, go to GRANT. Latency is 1 cycle from req to grant_valid.
  - If req==0: stay in IDLE; outputs unchanged (grant_valid=0).
  - arb_ack in IDLE is ignored.
- State GRANT:
  - grant_idx, grant_onehot and grant_valid are held stable until arb_ack, even if req[grant_idx] drops or other req bits change.
  - On arb_ack=1: ptr<=grant_idx. The next winner is computed from the current-cycle req with the updated ptr, i.e. the search starts at grant_idx+1.
  - If that req!=0: load the new winner and remain in GRANT. grant_valid stays 1 (back-to-back, no bubble).
  - If that req==0: grant_valid<=0, grant_onehot<=0, grant_idx holds its value, go to IDLE.
- Pointer arithmetic wraps modulo N_REQ (N_REQ-1 + 1 -> 0).
- Single requester held high continuously: it is re-granted after every ack, with no idle cycle.
- Simultaneous rst=0 and arb_ack: reset wins.
- rst asserted mid-grant: grant is dropped immediately; after release the search restarts at requester 0.
- Exactly one onehot bit is set whenever grant_valid=1.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to GRANT and on every new grant, then increments each GRANT cycle without arb_ack.
  - When it reaches TIMEOUT-1 without ack: arb_timeout pulses 1 for one cycle, ptr<=grant_idx (the stalled requester loses priority), and the next winner is selected exactly as for an ack.
  - arb_ack in the same cycle as expiry is treated as a normal ack; no timeout pulse.
- Not defined: no counter is built; arb_timeout is constant 0; a grant is held indefinitely until arb_ack.

Test Plan:
- Reset release, req=4'b0000 for 5 cycles -> grant_valid=0, grant_onehot=0.
- Then req=4'b1010 -> next cycle grant_valid=1, grant_idx=1, grant_onehot=4'b0010. Output stays stable for 10 cycles without ack, even when req changes to 4'b1000.
- req=4'b1111 constant, arb_ack pulsed every 3rd cycle -> grant_idx sequence 0,1,2,3,0 with grant_valid never dropping.
- Granted idx=3, req=4'b1001, ack -> next grant_idx=0 (wrap). Ack again with req=4'b1001 -> grant_idx=3.
- Grant active on idx=2, rst=0 pulsed between clock edges -> grant_valid=0 immediately. After release with req=4'b0100 -> grant_idx=2 one cycle later.
- ARB_TIMEOUT_EN, TIMEOUT=16, req=4'b0011, no ack -> arb_timeout=1 on the 16th grant cycle, grant moves 0->1. Repeat with ack on cycle 16 -> no timeout pulse, normal advance.
